// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//
// Selects which stored display pattern is presented to the pattern memory.
// Two modes:
//   AUTO - a dwell counter requests an advance every TICK_DIV clocks.
//   HOLD - the dwell counter is frozen; a btn_next rising edge requests one.
// A request only sets 'pending'. The index actually moves on a frame_done
// pulse, so the display never switches pattern in the middle of a scan.
//
// Parameters
//   TICK_DIV      clk cycles per auto-advance dwell (>= 2)
//   NUM_PATTERNS  number of stored patterns (1..16)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   btn_next      debounced level; rising edge requests next pattern (HOLD)
//   btn_mode      debounced level; rising edge toggles AUTO/HOLD
//   frame_done    one-cycle pulse at the end of a full refresh scan
//   patternIndex  registered pattern index
//   hold          1 in HOLD, 0 in AUTO
//   pending       1 while an advance request waits for frame_done
//   index_update  one-cycle pulse, one cycle after patternIndex changes
// ---------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int NUM_PATTERNS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_mode,
    input  logic       frame_done,
    output logic [3:0] patternIndex,
    output logic       hold,
    output logic       pending,
    output logic       index_update
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       NUM_P    = 5'(NUM_PATTERNS);

    typedef enum logic {
        S_AUTO = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             chg_q, chg_d;
    logic             upd_q, upd_d;
    logic             next_prev_q, mode_prev_q;

    logic             next_edge, mode_edge;
    logic             tick, next_req, req, adv;
    logic [4:0]       idx_inc;
    logic [3:0]       idx_wrap;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_AUTO;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            chg_q       <= 1'b0;
            upd_q       <= 1'b0;
            // Track the live button level through reset so a button held
            // across reset release is not seen as a fresh press.
            next_prev_q <= btn_next;
            mode_prev_q <= btn_mode;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            chg_q       <= chg_d;
            upd_q       <= upd_d;
            next_prev_q <= btn_next;
            mode_prev_q <= btn_mode;
        end
    end

    // -----------------------------------------------------------------------
    // Edge detection and request generation
    // -----------------------------------------------------------------------
    always_comb begin
        next_edge = btn_next & ~next_prev_q;
        mode_edge = btn_mode & ~mode_prev_q;

        // A mode toggle wins the cycle: the dwell counter restarts and a
        // btn_next press in the same cycle is dropped.
        tick     = (state_q == S_AUTO) && !mode_edge && (cnt_q == CNT_LAST);
        next_req = (state_q == S_HOLD) && !mode_edge && next_edge;
        req      = tick | next_req;

        // A request raised this cycle can be serviced by a coincident
        // frame_done without first passing through pending.
        adv      = frame_done & (pend_q | req);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            state_d = (state_q == S_AUTO) ? S_HOLD : S_AUTO;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (mode_edge) begin
            cnt_d = '0;
        end else if (state_q == S_AUTO) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        // Computed one bit wider so NUM_PATTERNS = 16 wraps correctly.
        idx_inc  = {1'b0, idx_q} + 5'd1;
        idx_wrap = (idx_inc == NUM_P) ? 4'd0 : idx_inc[3:0];
        idx_d    = adv ? idx_wrap : idx_q;

        // Requests collapse into a single pending flag. An advance consumes
        // it; only a dwell tick landing in that same cycle re-arms it, so a
        // long-waiting request cannot swallow the next auto period.
        if (adv) begin
            pend_d = pend_q & tick;
        end else begin
            pend_d = pend_q | req;
        end

        // Compare against the old index rather than using 'adv' so that a
        // wrap onto the same value (single pattern) produces no pulse.
        chg_d = (idx_d != idx_q);
        upd_d = chg_q;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        hold         = (state_q == S_HOLD);
        pending      = pend_q;
        patternIndex = idx_q;
        index_update = upd_q;
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
//
// Bench for pattern_sequencer at TICK_DIV=10, NUM_PATTERNS=6, with a second
// single-pattern instance sharing the same stimulus. Expected indices are
// queued when the causing stimulus is driven and popped whenever the DUT
// raises index_update.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_mode = 1'b0;
    logic       frame_done = 1'b0;
    logic [3:0] patternIndex;
    logic       hold, pending, index_update;
    logic [3:0] idx1;
    logic       hold1, pend1, upd1;

    always #5 clk = ~clk;

    pattern_sequencer #(.TICK_DIV(10), .NUM_PATTERNS(6)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_mode(btn_mode),
        .frame_done(frame_done), .patternIndex(patternIndex), .hold(hold),
        .pending(pending), .index_update(index_update)
    );

    pattern_sequencer #(.TICK_DIV(10), .NUM_PATTERNS(1)) dut_one (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_mode(btn_mode),
        .frame_done(frame_done), .patternIndex(idx1), .hold(hold1),
        .pending(pend1), .index_update(upd1)
    );

    typedef struct {
        logic       n;
        logic       m;
        logic       fd;
        logic [3:0] idx;
        logic       hold;
        logic       pend;
    } vec_t;

    vec_t       vecs[24];
    logic [3:0] sb[$];
    int         tests = 0;
    int         fails = 0;
    int         upd_cnt = 0;
    int         upd1_cnt = 0;
    int         idx1_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (index_update) begin
            upd_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_update: got idx %0d expected no update", patternIndex);
            end else begin
                e = sb.pop_front();
                chk("sb_idx", patternIndex, e);
            end
        end
        if (upd1) upd1_cnt++;
        if (idx1 != 4'd0) idx1_bad++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic setv(input int i, input logic n, input logic m, input logic fd,
                        input logic [3:0] idx, input logic h, input logic p);
        vecs[i].n = n;  vecs[i].m = m;  vecs[i].fd = fd;
        vecs[i].idx = idx;  vecs[i].hold = h;  vecs[i].pend = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         adv_k[6];
        int         ai;
        logic [3:0] e_idx;
        logic [3:0] last_exp;
        int         upd_before;
        int         first;

        // HOLD/AUTO corner table (outputs observed after each edge)
        //        i   n  m  fd idx hold pend
        setv( 0, 0, 1, 0, 0, 1, 0);
        setv( 1, 0, 0, 0, 0, 1, 0);
        setv( 2, 1, 0, 0, 0, 1, 1);
        setv( 3, 0, 0, 0, 0, 1, 1);
        setv( 4, 1, 0, 0, 0, 1, 1);
        setv( 5, 0, 0, 0, 0, 1, 1);
        setv( 6, 1, 0, 0, 0, 1, 1);
        setv( 7, 0, 0, 1, 1, 1, 0);   // three presses collapse to one advance
        setv( 8, 0, 0, 0, 1, 1, 0);
        setv( 9, 1, 0, 1, 2, 1, 0);   // press + frame_done same cycle
        setv(10, 0, 0, 0, 2, 1, 0);
        setv(11, 0, 0, 0, 2, 1, 0);
        setv(12, 1, 1, 0, 2, 0, 0);   // mode + next together: toggle only
        setv(13, 0, 0, 0, 2, 0, 0);
        setv(14, 0, 1, 0, 2, 1, 0);
        setv(15, 1, 0, 0, 2, 1, 1);
        setv(16, 0, 0, 0, 2, 1, 1);
        setv(17, 0, 1, 0, 2, 0, 1);   // toggle keeps pending
        setv(18, 0, 0, 1, 3, 0, 0);
        setv(19, 0, 0, 0, 3, 0, 0);
        setv(20, 0, 1, 0, 3, 1, 0);
        setv(21, 1, 0, 0, 3, 1, 1);
        setv(22, 0, 1, 1, 4, 0, 0);   // toggle + frame_done same cycle
        setv(23, 0, 0, 0, 4, 0, 0);

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_idx", patternIndex, 0);
        chk("rst_hold", hold, 0);
        chk("rst_pend", pending, 0);
        chk("rst_upd", index_update, 0);

        // ---------------- AUTO run, frame_done every 3 cycles ----------------
        adv_k[0] = 12; adv_k[1] = 21; adv_k[2] = 30;
        adv_k[3] = 42; adv_k[4] = 51; adv_k[5] = 60;
        ai = 0;
        e_idx = 4'd0;
        upd_before = upd_cnt;
        for (int k = 1; k <= 65; k++) begin
            frame_done = (k % 3 == 0);
            if (ai < 6 && adv_k[ai] == k) begin
                e_idx = (e_idx == 4'd5) ? 4'd0 : e_idx + 4'd1;
                sb.push_back(e_idx);
                ai++;
            end
            step();
            if (k == 9)  chk("auto_pend_early", pending, 0);
            if (k == 10) chk("auto_pend_rise", pending, 1);
            if (k == 11) chk("auto_idx_wait", patternIndex, 0);
            if (k == 12) begin
                chk("auto_idx_adv", patternIndex, 1);
                chk("auto_upd_not_yet", index_update, 0);
                chk("auto_pend_clr", pending, 0);
            end
            if (k == 13) chk("auto_upd_pulse", index_update, 1);
            if (k == 14) chk("auto_upd_single", index_update, 0);
            if (k == 60) chk("auto_wrap_idx", patternIndex, 0);
        end
        frame_done = 1'b0;
        chk("auto_upd_count", upd_cnt - upd_before, 6);

        // ---------------- table-driven HOLD/toggle corners ----------------
        do_reset();
        last_exp = 4'd0;
        for (int i = 0; i < 24; i++) begin
            btn_next   = vecs[i].n;
            btn_mode   = vecs[i].m;
            frame_done = vecs[i].fd;
            if (vecs[i].idx != last_exp) sb.push_back(vecs[i].idx);
            last_exp = vecs[i].idx;
            step();
            chk($sformatf("vec%0d_idx", i), patternIndex, vecs[i].idx);
            chk($sformatf("vec%0d_hold", i), hold, vecs[i].hold);
            chk($sformatf("vec%0d_pend", i), pending, vecs[i].pend);
        end
        btn_next = 1'b0; btn_mode = 1'b0; frame_done = 1'b0;
        step();

        // ---------------- reset with pending set and btn_next held ----------
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        btn_next = 1'b1; step();
        chk("pre_rst_pend", pending, 1);
        chk("pre_rst_idx", patternIndex, 4);
        chk("pre_rst_hold", hold, 1);
        rst = 1'b1; frame_done = 1'b1;
        step();
        chk("mid_rst_idx", patternIndex, 0);
        chk("mid_rst_hold", hold, 0);
        chk("mid_rst_pend", pending, 0);
        chk("mid_rst_upd", index_update, 0);
        rst = 1'b0; frame_done = 1'b0;
        step();
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        chk("post_rst_hold", hold, 1);
        for (int i = 0; i < 4; i++) begin
            frame_done = (i % 2 == 0);
            step();
            chk("held_btn_idx", patternIndex, 0);
            chk("held_btn_pend", pending, 0);
        end
        frame_done = 1'b0;
        btn_next = 1'b0; step();
        btn_next = 1'b1; step();
        chk("new_edge_pend", pending, 1);
        frame_done = 1'b1; sb.push_back(4'd1);
        step();
        chk("new_edge_idx", patternIndex, 1);
        frame_done = 1'b0; btn_next = 1'b0;
        step();
        step();

        // ---------------- toggle at dwell count 7 ----------------
        do_reset();
        for (int i = 0; i < 7; i++) step();
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        chk("dwell7_hold", hold, 1);
        for (int i = 0; i < 15; i++) step();
        chk("dwell_frozen_pend", pending, 0);
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
        chk("dwell_back_auto", hold, 0);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pending && first < 0) first = k;
        end
        chk("dwell_restart_cycles", first, 10);

        // ---------------- end-of-run checks ----------------
        chk("sb_drained", sb.size(), 0);
        chk("one_pat_upd_count", upd1_cnt, 0);
        chk("one_pat_idx_nonzero", idx1_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
